// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract iteration of the divider.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The held remainder is always below dvs, so the shifted value needs one extra bit.
  assign shifted = {rem, dvd_msb};
  assign q_bit   = (shifted >= {1'b0, dvs});

  // When q_bit is set the true difference is below dvs, so modulo-2^WIDTH math is exact.
  assign diff     = shifted[WIDTH-1:0] - dvs;
  assign next_rem = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/int_divider.sv
// Multi-cycle unsigned divider: samples operands in IDLE, one quotient bit per clock, publishes in DONE.
module int_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             divFlag,
  output logic [WIDTH-1:0] divOut
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] next_rem;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  // NOTE: every register here is written with <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      quo     <= '0;
      divOut  <= '0;
      divFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dvd   <= src1;
          dvs   <= src2;
          rem   <= '0;
          quo   <= '0;
          cnt   <= CNT_W'(WIDTH - 1);
          state <= BUSY;
        end
        BUSY: begin
          rem <= next_rem;
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          quo <= {quo[WIDTH-2:0], q_bit};
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          // A zero divisor is not trapped; the all-ones quotient falls out of the algorithm.
          divOut  <= quo;
          divFlag <= (dvs == '0);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider: directed cases plus random operands against an arithmetic model.
module tb_int_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        divFlag;
  logic [31:0] divOut;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_out  = '0;
  logic        exp_flag = 1'b0;

  int_divider dut (
    .clk     (clk),
    .reset   (reset),
    .src1    (src1),
    .src2    (src2),
    .divFlag (divFlag),
    .divOut  (divOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just before an IDLE sampling edge; returns #1 after the DONE edge that publishes the result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] q;
    logic        f;
    f = (b == 32'd0);
    q = f ? 32'hFFFF_FFFF : a / b;
    src1 = a;
    src2 = b;
    @(posedge clk);
    #1;
    src1 = $urandom;
    src2 = $urandom;
    repeat (20) @(posedge clk);
    #1;
    check({tag, " hold out"}, divOut, exp_out);
    check({tag, " hold flag"}, {31'd0, divFlag}, {31'd0, exp_flag});
    repeat (13) @(posedge clk);
    #1;
    check({tag, " out"}, divOut, q);
    check({tag, " flag"}, {31'd0, divFlag}, {31'd0, f});
    exp_out  = q;
    exp_flag = f;
  endtask

  initial begin
    reset = 1'b1;
    src1  = '0;
    src2  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset out", divOut, 32'd0);
    check("reset flag", {31'd0, divFlag}, 32'd0);

    run_div(32'd8, 32'd2, "8/2");
    run_div(32'd6, 32'd2, "6/2");
    run_div(32'd4, 32'd2, "4/2");
    run_div(32'd2, 32'd2, "2/2");
    run_div(32'd7, 32'd0, "7/0");
    run_div(32'd9, 32'd3, "9/3");
    run_div(32'hFFFF_FFFF, 32'd1, "max/1");
    run_div(32'd5, 32'd9, "5/9");
    run_div(32'hDEAD_BEEF, 32'hDEAD_BEEF, "eq");
    run_div(32'd7, 32'd0, "pre-reset 7/0");

    // Reset lands on the 10th BUSY edge of a 100/7 division.
    src1 = 32'd100;
    src2 = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid reset out", divOut, 32'd0);
    check("mid reset flag", {31'd0, divFlag}, 32'd0);
    exp_out  = '0;
    exp_flag = 1'b0;
    run_div(32'd100, 32'd7, "100/7 after reset");

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = 32'd0;
        default: b = a >> $urandom_range(0, 31);
      endcase
      run_div(a, b, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
